// File: rtl/ibex_shadow_stack_ctrl.sv
// Return-address shadow stack: calls push, returns pop and compare.
// Supports replace (push+pop), flush, selectable overflow policy and a sticky error cause.
module ibex_shadow_stack_ctrl #(
    parameter int unsigned Depth        = 32,
    parameter int unsigned Width        = 32,
    parameter bit          OverflowWrap = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       en_i,
    input  logic                       push_i,
    input  logic [Width-1:0]           push_addr_i,
    input  logic                       pop_i,
    input  logic [Width-1:0]           pop_addr_i,
    input  logic                       flush_i,
    input  logic                       clear_err_i,
    output logic                       check_valid_o,
    output logic                       check_fail_o,
    output logic                       error_o,
    output logic [1:0]                 err_cause_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);
    localparam logic [CntW-1:0] CntOne   = CntW'(1);
    localparam logic [CntW-1:0] CntDepth = CntW'(Depth);

    localparam logic [1:0] CauseMismatch  = 2'd1;
    localparam logic [1:0] CauseUnderflow = 2'd2;
    localparam logic [1:0] CauseOverflow  = 2'd3;

    logic [Width-1:0] mem [Depth];
    logic [PtrW-1:0]  wp_q, wp_d, top_ptr, waddr;
    logic [CntW-1:0]  count_q, count_d;
    logic             we;
    logic             full, empty, do_push, do_pop, mismatch;
    logic             chk_valid_d, chk_fail_d, chk_valid_q, chk_fail_q;
    logic             err_ev, error_q;
    logic [1:0]       err_cause_ev, err_cause_q;

    assign full     = (count_q == CntDepth);
    assign empty    = (count_q == '0);
    assign top_ptr  = wp_q - PtrOne;
    assign do_push  = en_i & push_i & ~flush_i;
    assign do_pop   = en_i & pop_i & ~flush_i;
    assign mismatch = (mem[top_ptr] != pop_addr_i);

    // check_valid_o is a single-cycle pulse, one cycle after an accepted pop;
    // check_fail_o is meaningful only while check_valid_o is high.
    always_comb begin
        wp_d         = wp_q;
        count_d      = count_q;
        we           = 1'b0;
        waddr        = wp_q;
        chk_valid_d  = 1'b0;
        chk_fail_d   = 1'b0;
        err_ev       = 1'b0;
        err_cause_ev = 2'd0;
        if (flush_i) begin
            wp_d    = '0;
            count_d = '0;
        end else if (do_pop && do_push) begin
            chk_valid_d = 1'b1;
            we          = 1'b1;
            if (empty) begin
                chk_fail_d   = 1'b1;
                err_ev       = 1'b1;
                err_cause_ev = CauseUnderflow;
                wp_d         = wp_q + PtrOne;
                count_d      = count_q + CntOne;
            end else begin
                // Replace the top in place: pointer and count stay put.
                chk_fail_d   = mismatch;
                err_ev       = mismatch;
                err_cause_ev = CauseMismatch;
                waddr        = top_ptr;
            end
        end else if (do_pop) begin
            chk_valid_d = 1'b1;
            if (empty) begin
                chk_fail_d   = 1'b1;
                err_ev       = 1'b1;
                err_cause_ev = CauseUnderflow;
            end else begin
                chk_fail_d   = mismatch;
                err_ev       = mismatch;
                err_cause_ev = CauseMismatch;
                wp_d         = top_ptr;
                count_d      = count_q - CntOne;
            end
        end else if (do_push) begin
            if (!full) begin
                we      = 1'b1;
                wp_d    = wp_q + PtrOne;
                count_d = count_q + CntOne;
            end else if (OverflowWrap) begin
                // wp points at the oldest entry when full.
                we   = 1'b1;
                wp_d = wp_q + PtrOne;
            end else begin
                err_ev       = 1'b1;
                err_cause_ev = CauseOverflow;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wp_q        <= '0;
            count_q     <= '0;
            chk_valid_q <= 1'b0;
            chk_fail_q  <= 1'b0;
            error_q     <= 1'b0;
            err_cause_q <= 2'd0;
        end else begin
            wp_q        <= wp_d;
            count_q     <= count_d;
            chk_valid_q <= chk_valid_d;
            chk_fail_q  <= chk_fail_d;
            // First cause wins; a clear in the same cycle lets a new error in.
            if (err_ev && (!error_q || clear_err_i)) begin
                error_q     <= 1'b1;
                err_cause_q <= err_cause_ev;
            end else if (clear_err_i) begin
                error_q     <= 1'b0;
                err_cause_q <= 2'd0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (we) begin
            mem[waddr] <= push_addr_i;
        end
    end

    assign check_valid_o = chk_valid_q;
    assign check_fail_o  = chk_fail_q;
    assign error_o       = error_q;
    assign err_cause_o   = err_cause_q;
    assign count_o       = count_q;
    assign full_o        = full;
    assign empty_o       = empty;
endmodule

// File: tb/tb_ibex_shadow_stack_ctrl.sv
// Bench for ibex_shadow_stack_ctrl: two Depth=4 instances (drop / wrap overflow)
// driven identically, checked every cycle against a queue-based stack model.
module tb_ibex_shadow_stack_ctrl;
    localparam int W = 32;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b1;
    logic         push = 1'b0;
    logic [W-1:0] push_addr = '0;
    logic         pop = 1'b0;
    logic [W-1:0] pop_addr = '0;
    logic         flush = 1'b0;
    logic         clr = 1'b0;

    logic         cv [2];
    logic         cf [2];
    logic         err [2];
    logic [1:0]   cause [2];
    logic [2:0]   cnt [2];
    logic         full [2];
    logic         empty [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ibex_shadow_stack_ctrl #(.Depth(D), .Width(W), .OverflowWrap(1'b0)) u_drop (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .push_i(push), .push_addr_i(push_addr),
        .pop_i(pop), .pop_addr_i(pop_addr), .flush_i(flush), .clear_err_i(clr),
        .check_valid_o(cv[0]), .check_fail_o(cf[0]), .error_o(err[0]),
        .err_cause_o(cause[0]), .count_o(cnt[0]), .full_o(full[0]), .empty_o(empty[0])
    );

    ibex_shadow_stack_ctrl #(.Depth(D), .Width(W), .OverflowWrap(1'b1)) u_wrap (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .push_i(push), .push_addr_i(push_addr),
        .pop_i(pop), .pop_addr_i(pop_addr), .flush_i(flush), .clear_err_i(clr),
        .check_valid_o(cv[1]), .check_fail_o(cf[1]), .error_o(err[1]),
        .err_cause_o(cause[1]), .count_o(cnt[1]), .full_o(full[1]), .empty_o(empty[1])
    );

    // Model: a plain LIFO of addresses per instance; index 1 wraps on overflow.
    logic [W-1:0] exp_q [2][$];
    logic         m_cv [2];
    logic         m_cf [2];
    logic         m_err [2];
    logic [1:0]   m_cause [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic         ev;
            logic [1:0]   c;
            logic [W-1:0] top;
            ev = 1'b0;
            c  = 2'd0;
            m_cv[k] = 1'b0;
            m_cf[k] = 1'b0;
            if (!rst_n) begin
                exp_q[k].delete();
                m_err[k]   = 1'b0;
                m_cause[k] = 2'd0;
            end else begin
                if (flush) begin
                    exp_q[k].delete();
                end else if (en) begin
                    if (pop) begin
                        m_cv[k] = 1'b1;
                        if (exp_q[k].size() == 0) begin
                            m_cf[k] = 1'b1; ev = 1'b1; c = 2'd2;
                        end else begin
                            top = exp_q[k].pop_back();
                            if (top != pop_addr) begin
                                m_cf[k] = 1'b1; ev = 1'b1; c = 2'd1;
                            end
                        end
                    end
                    if (push) begin
                        if (exp_q[k].size() < D) begin
                            exp_q[k].push_back(push_addr);
                        end else if (k == 1) begin
                            void'(exp_q[k].pop_front());
                            exp_q[k].push_back(push_addr);
                        end else begin
                            ev = 1'b1; c = 2'd3;
                        end
                    end
                end
                if (ev && (!m_err[k] || clr)) begin
                    m_err[k] = 1'b1; m_cause[k] = c;
                end else if (clr) begin
                    m_err[k] = 1'b0; m_cause[k] = 2'd0;
                end
            end
        end
    end

    task automatic cmp(input string name, input int k, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] t=%0t got=%0h expected=%0h", name, k, $time, act, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        for (int k = 0; k < 2; k++) begin
            cmp("check_valid", k, W'(cv[k]), W'(m_cv[k]));
            if (m_cv[k]) cmp("check_fail", k, W'(cf[k]), W'(m_cf[k]));
            cmp("error", k, W'(err[k]), W'(m_err[k]));
            cmp("err_cause", k, W'(cause[k]), W'(m_cause[k]));
            cmp("count", k, W'(cnt[k]), W'(exp_q[k].size()));
            cmp("full", k, W'(full[k]), W'(exp_q[k].size() == D));
            cmp("empty", k, W'(empty[k]), W'(exp_q[k].size() == 0));
        end
    end

    task automatic step(input logic p, input logic [W-1:0] pa, input logic q,
                        input logic [W-1:0] qa, input logic fl = 1'b0,
                        input logic e = 1'b1, input logic c = 1'b0, input logic r = 1'b1);
        @(negedge clk);
        push = p; push_addr = pa; pop = q; pop_addr = qa;
        flush = fl; en = e; clr = c; rst_n = r;
        @(posedge clk);
        #2;
    endtask

    task automatic do_push(input logic [W-1:0] a);
        step(1'b1, a, 1'b0, '0);
    endtask

    task automatic do_pop(input logic [W-1:0] a);
        step(1'b0, '0, 1'b1, a);
    endtask

    task automatic do_reset();
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0, '0);
    endtask

    initial begin
        logic [W-1:0] abcde [5];
        abcde = '{32'hA0, 32'hB0, 32'hC0, 32'hD0, 32'hE0};

        do_reset();
        cmp("lit_reset_count", 0, W'(cnt[0]), 32'd0);
        cmp("lit_reset_empty", 0, W'(empty[0]), 32'd1);

        // Basic LIFO order.
        do_push(32'h100); do_push(32'h200); do_push(32'h300);
        cmp("lit_count3", 0, W'(cnt[0]), 32'd3);
        do_pop(32'h300);
        cmp("lit_pulse", 0, W'(cv[0]), 32'd1);
        cmp("lit_pass", 0, W'(cf[0]), 32'd0);
        do_pop(32'h200); do_pop(32'h100);
        cmp("lit_count0", 0, W'(cnt[0]), 32'd0);
        cmp("lit_no_err", 0, W'(err[0]), 32'd0);

        // Overflow, drop policy (instance 0).
        do_reset();
        for (int i = 0; i < 5; i++) do_push(abcde[i]);
        cmp("lit_ovf_err", 0, W'(err[0]), 32'd1);
        cmp("lit_ovf_cause", 0, W'(cause[0]), 32'd3);
        cmp("lit_ovf_count", 0, W'(cnt[0]), 32'd4);
        cmp("lit_wrap_noerr", 1, W'(err[1]), 32'd0);
        for (int i = 3; i >= 0; i--) do_pop(abcde[i]);

        // Overflow, wrap policy (instance 1).
        do_reset();
        for (int i = 0; i < 5; i++) do_push(abcde[i]);
        for (int i = 4; i >= 1; i--) begin
            do_pop(abcde[i]);
            cmp("lit_wrap_pass", 1, W'(cf[1]), 32'd0);
        end
        do_pop(32'hF0);
        cmp("lit_wrap_underflow", 1, W'(cf[1]), 32'd1);
        cmp("lit_wrap_cause", 1, W'(cause[1]), 32'd2);

        // Mismatch, sticky cause, clear, clear with simultaneous error.
        do_reset();
        do_push(32'h40);
        do_pop(32'h44);
        cmp("lit_mm_fail", 0, W'(cf[0]), 32'd1);
        cmp("lit_mm_cause", 0, W'(cause[0]), 32'd1);
        do_pop(32'h0);
        cmp("lit_sticky_cause", 0, W'(cause[0]), 32'd1);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
        cmp("lit_cleared", 0, W'(err[0]), 32'd0);
        do_pop(32'h0);
        step(1'b0, '0, 1'b1, 32'h0, 1'b0, 1'b1, 1'b1);
        cmp("lit_clear_new", 0, W'(cause[0]), 32'd2);
        step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, 1'b1);

        // Replace, and push+pop on empty.
        do_push(32'h10);
        step(1'b1, 32'h20, 1'b1, 32'h10);
        cmp("lit_replace_count", 0, W'(cnt[0]), 32'd1);
        do_pop(32'h20);
        cmp("lit_replace_pass", 0, W'(cf[0]), 32'd0);
        step(1'b1, 32'h55, 1'b1, 32'h55);
        do_pop(32'h55);

        // Flush with pop, enable gating, reset mid-sequence.
        do_push(32'h1); do_push(32'h2); do_push(32'h3);
        step(1'b0, '0, 1'b1, 32'h3, 1'b1);
        cmp("lit_flush_count", 0, W'(cnt[0]), 32'd0);
        cmp("lit_flush_nocheck", 0, W'(cv[0]), 32'd0);
        do_push(32'h7);
        step(1'b1, 32'h8, 1'b1, 32'h7, 1'b0, 1'b0);
        cmp("lit_en_gate", 0, W'(cnt[0]), 32'd1);
        do_pop(32'h9);
        do_push(32'hA);
        step(1'b0, '0, 1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 1'b0);
        cmp("lit_rst_count", 0, W'(cnt[0]), 32'd0);
        cmp("lit_rst_err", 0, W'(err[0]), 32'd0);
        cmp("lit_rst_cv", 0, W'(cv[0]), 32'd0);
        step(1'b0, '0, 1'b0, '0);
        step(1'b0, '0, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
